logic_analyzer_capture_fsm: RTL and testbench



---
 rtl/logic_analyzer_capture_fsm_if.sv | 28 ++
 rtl/logic_analyzer_capture_fsm.sv | 128 ++++++++++++
 tb/tb_logic_analyzer_capture_fsm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/logic_analyzer_capture_fsm_if.sv
// Host/trigger/sample-memory bundle for the logic analyzer capture sequencer.
// master = host side driving the request fields; slave = the capture FSM.
interface logic_analyzer_capture_fsm_if #(
  parameter int unsigned SAMPLE_DEPTH = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(SAMPLE_DEPTH);

  logic                  trigger;
  logic [1:0]            trigger_mode;
  logic [15:0]           trigger_loc;
  logic                  request_start;
  logic                  request_stop;
  logic [3:0]            state;
  logic [ADDR_WIDTH-1:0] read_pointer;
  logic [ADDR_WIDTH-1:0] write_pointer;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;

  modport master (
    output trigger, trigger_mode, trigger_loc, request_start, request_stop,
    input  state, read_pointer, write_pointer, bram_we, bram_addr
  );

  modport slave (
    input  trigger, trigger_mode, trigger_loc, request_start, request_stop,
    output state, read_pointer, write_pointer, bram_we, bram_addr
  );
endinterface

// File: rtl/logic_analyzer_capture_fsm.sv
// Capture sequencer: drives the sample buffer write port and circular read/write pointers.
// Optional LA_FSM_TRIG_SYNC_EN registers the trigger input once before use.
module logic_analyzer_capture_fsm #(
  parameter int unsigned SAMPLE_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  logic_analyzer_capture_fsm_if.slave   bus
);
  localparam int unsigned           ADDR_WIDTH = $clog2(SAMPLE_DEPTH);
  localparam logic [15:0]           LOC_MAX    = 16'(SAMPLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX    = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE             = 4'd0,
    MOVE_TO_POSITION = 4'd1,
    IN_POSITION      = 4'd2,
    CAPTURING        = 4'd3,
    CAPTURED         = 4'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] wr_inc, rd_inc, loc_eff;
  logic                  start_q;
  logic                  start_evt;
  logic                  trig;
  logic                  single_shot;
  logic                  incremental;
  logic                  we_c;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_MAX) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

`ifdef LA_FSM_TRIG_SYNC_EN
  logic trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= bus.trigger;
  end

  assign trig = trig_q;
`else
  assign trig = bus.trigger;
`endif

  assign start_evt   = bus.request_start & ~start_q;
  assign single_shot = (bus.trigger_mode == 2'd0) || (bus.trigger_mode == 2'd3);
  assign incremental = (bus.trigger_mode == 2'd1);
  assign loc_eff     = (bus.trigger_loc > LOC_MAX) ? PTR_MAX : ADDR_WIDTH'(bus.trigger_loc);
  assign wr_inc      = ptr_inc(wr_q);
  assign rd_inc      = ptr_inc(rd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      start_q <= bus.request_start;
    end
  end

  // Write enable depends only on state and trigger; stop/start act on the registered side.
  always_comb begin
    we_c = 1'b0;
    case (state_q)
      MOVE_TO_POSITION,
      IN_POSITION: we_c = 1'b1;
      CAPTURING:   we_c = incremental ? trig : 1'b1;
      default:     we_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (bus.request_stop) begin
      state_d = IDLE;
      rd_d    = '0;
      wr_d    = '0;
    end else if (start_evt && (state_q == IDLE || state_q == CAPTURED)) begin
      rd_d = '0;
      wr_d = '0;
      if (single_shot) state_d = (loc_eff == '0) ? IN_POSITION : MOVE_TO_POSITION;
      else             state_d = CAPTURING;
    end else begin
      case (state_q)
        IDLE, CAPTURED: ;
        MOVE_TO_POSITION: begin
          wr_d = wr_inc;
          if (wr_inc == loc_eff) state_d = IN_POSITION;
        end
        IN_POSITION: begin
          // Read pointer trails the writer to keep exactly loc_eff pre-trigger samples.
          wr_d = wr_inc;
          if (trig) state_d = (wr_inc == rd_q) ? CAPTURED : CAPTURING;
          else      rd_d    = rd_inc;
        end
        CAPTURING: begin
          if (we_c) begin
            wr_d = wr_inc;
            if (wr_inc == rd_q) state_d = CAPTURED;
          end
        end
        default: begin
          state_d = IDLE;
          rd_d    = '0;
          wr_d    = '0;
        end
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.read_pointer  = rd_q;
  assign bus.write_pointer = wr_q;
  assign bus.bram_we       = we_c;
  assign bus.bram_addr     = wr_q;
endmodule

// File: tb/tb_logic_analyzer_capture_fsm.sv
// Scoreboard bench for logic_analyzer_capture_fsm: expected writes/state transitions are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_logic_analyzer_capture_fsm;
  logic clk;
  logic rst_n;

  logic_analyzer_capture_fsm_if #(.SAMPLE_DEPTH(8)) bus ();

  logic_analyzer_capture_fsm #(.SAMPLE_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_writes[$];
  int exp_states[$];
  logic [3:0] prev_state;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every state change and every write (outside a stop cycle) must match the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_state = 4'd0;
    end else begin
      if (bus.state != prev_state) begin
        if (exp_states.size() == 0) check("unexpected_state_change", int'(bus.state), int'(prev_state));
        else                        check("state_seq", int'(bus.state), exp_states.pop_front());
        prev_state = bus.state;
      end
      if (bus.bram_we && !bus.request_stop) begin
        if (exp_writes.size() == 0) check("unexpected_write_addr", int'(bus.bram_addr), -1);
        else                        check("write_addr", int'(bus.bram_addr), exp_writes.pop_front());
      end
    end
  end

  task automatic start_edge(input logic [1:0] mode, input logic [15:0] loc);
    bus.trigger_mode  = mode;
    bus.trigger_loc   = loc;
    bus.request_start = 1'b1;
    cyc();
    bus.request_start = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.trigger       = 1'b0;
    bus.trigger_mode  = 2'd0;
    bus.trigger_loc   = 16'd0;
    bus.request_start = 1'b0;
    bus.request_stop  = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc();

    // Reset state and trigger ignored in IDLE
    check("rst_state", int'(bus.state), 0);
    check("rst_rd", int'(bus.read_pointer), 0);
    check("rst_wr", int'(bus.write_pointer), 0);
    check("rst_we", int'(bus.bram_we), 0);
    bus.trigger = 1'b1;
    cyc(2);
    bus.trigger = 1'b0;
    check("idle_trigger_state", int'(bus.state), 0);

    // Single-shot, loc=3, trigger 10 cycles into IN_POSITION
    exp_states = '{1, 2, 3, 4};
    exp_writes = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    start_edge(2'd0, 16'd3);
    check("ss_first_we", int'(bus.bram_we), 1);
    cyc(3);
    check("ss_in_pos", int'(bus.state), 2);
    cyc(10);
    check("ss_trig_addr", int'(bus.bram_addr), 5);
    bus.trigger = 1'b1;
    cyc();
    bus.trigger = 1'b0;
    check("ss_capturing", int'(bus.state), 3);
    cyc(4);
    check("ss_captured", int'(bus.state), 4);
    check("ss_rd", int'(bus.read_pointer), 2);
    check("ss_wr", int'(bus.write_pointer), 2);
    cyc(2);

    // Immediate mode: 8 writes 0..7 then CAPTURED with pointers at 0
    exp_states = '{3, 4};
    exp_writes = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_edge(2'd2, 16'd5);
    check("imm_state", int'(bus.state), 3);
    cyc(7);
    check("imm_still_cap", int'(bus.state), 3);
    cyc();
    check("imm_captured", int'(bus.state), 4);
    check("imm_rd", int'(bus.read_pointer), 0);
    check("imm_wr", int'(bus.write_pointer), 0);
    cyc(2);

    // Incremental: writes only on 8 isolated trigger cycles
    exp_states = '{3, 4};
    exp_writes = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_edge(2'd1, 16'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1 + (i % 3));
      check("inc_no_fill_yet", int'(bus.state), 3);
      bus.trigger = 1'b1;
      cyc();
      bus.trigger = 1'b0;
    end
    check("inc_captured", int'(bus.state), 4);
    cyc(2);

    // loc=20 clamps to 7; trigger on first IN_POSITION cycle fills the buffer directly
    exp_states = '{1, 2, 4};
    exp_writes = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_edge(2'd0, 16'd20);
    cyc(6);
    check("clamp_move", int'(bus.state), 1);
    cyc();
    check("clamp_in_pos", int'(bus.state), 2);
    bus.trigger = 1'b1;
    cyc();
    bus.trigger = 1'b0;
    check("clamp_captured", int'(bus.state), 4);
    check("clamp_rd", int'(bus.read_pointer), 0);
    check("clamp_wr", int'(bus.write_pointer), 0);
    cyc(2);

    // Stop mid-capture wins over a simultaneous start edge
    exp_states = '{3, 0};
    exp_writes = '{0, 1, 2};
    start_edge(2'd2, 16'd0);
    cyc(3);
    bus.request_stop  = 1'b1;
    bus.request_start = 1'b1;
    cyc();
    check("stop_state", int'(bus.state), 0);
    check("stop_rd", int'(bus.read_pointer), 0);
    check("stop_wr", int'(bus.write_pointer), 0);
    check("stop_we", int'(bus.bram_we), 0);
    bus.request_stop = 1'b0;
    cyc(2);
    check("no_edge_after_stop", int'(bus.state), 0);
    bus.request_start = 1'b0;
    cyc(2);

    check("writes_left", exp_writes.size(), 0);
    check("states_left", exp_states.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
